// File: rtl/role_decouple_pkg.sv
// role_decouple_pkg: shared types and helpers for the role AXI decoupler.
//   state_t  : decoupler FSM state (RUN / BLOCK / DECOUPLED)
//   CNT_*    : lane index of each outstanding counter in the counter array
//   cnt_w()  : counter width able to hold 0..max inclusive
package role_decouple_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BLOCK     = 2'd1,
    DECOUPLED = 2'd2
  } state_t;

  localparam int NUM_CNT = 3;
  localparam int CNT_WR  = 0;  // AW accepted, B not yet returned
  localparam int CNT_RD  = 1;  // AR accepted, rlast not yet returned
  localparam int CNT_WP  = 2;  // AW accepted, wlast not yet sent

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/outstanding_cnt.sv
// outstanding_cnt: saturating up/down burst counter.
//   gclk, grst_n : clock, synchronous active-low reset
//   inc, dec     : count up / down one; both in one cycle leave the count as is
//   clr          : synchronous clear to 0 (wins over inc/dec)
//   cnt          : current count
//   full, empty  : cnt == MAX, cnt == 0
// Increments at MAX and decrements at 0 are dropped so the count never wraps.
module outstanding_cnt #(
  parameter int CNT_W = 5,
  parameter int MAX   = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  assign full  = (cnt == MAX_V);
  assign empty = (cnt == '0);

  always_ff @(posedge gclk) begin
    if (!grst_n)                    cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && !dec && !full)  cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && !empty) cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/role_axi_decoupler.sv
// role_axi_decoupler: partial-reconfiguration isolation shim between a role's
// AXI4 master (S_AXI_ROLE_*) and the static-region slave (M_AXI_STATIC_*).
//   CLK_IN_250       : sole clock, rising edge
//   AXI_RESET_N      : synchronous active-low reset
//   DECOUPLE_REQ     : level request to isolate the role
//   DECOUPLE_ACK     : registered, 1 while the role is fully isolated
//   DRAIN_TIMEOUT    : sticky, last isolation was forced by the drain timer
//   OUTSTANDING_WR/RD: live write / read burst counts
// Payload fields are wired straight through; only valid/ready are gated, so
// there is no added latency. The gates depend only on registered state.
// Optional feature macro: ROLE_DECOUPLE_TIMEOUT_EN adds a drain timer that
// forces isolation after TIMEOUT_CYCLES in BLOCK.
module role_axi_decoupler
  import role_decouple_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int CNT_W          = cnt_w(MAX_OUTSTANDING)
) (
  input  logic                CLK_IN_250,
  input  logic                AXI_RESET_N,
  input  logic                DECOUPLE_REQ,
  output logic                DECOUPLE_ACK,
  output logic                DRAIN_TIMEOUT,
  output logic [CNT_W-1:0]    OUTSTANDING_WR,
  output logic [CNT_W-1:0]    OUTSTANDING_RD,
  // role side (we are the slave)
  input  logic [ADDR_W-1:0]   S_AXI_ROLE_AWADDR,
  input  logic [7:0]          S_AXI_ROLE_AWLEN,
  input  logic [2:0]          S_AXI_ROLE_AWSIZE,
  input  logic [1:0]          S_AXI_ROLE_AWBURST,
  input  logic                S_AXI_ROLE_AWVALID,
  output logic                S_AXI_ROLE_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_ROLE_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_ROLE_WSTRB,
  input  logic                S_AXI_ROLE_WLAST,
  input  logic                S_AXI_ROLE_WVALID,
  output logic                S_AXI_ROLE_WREADY,
  output logic [1:0]          S_AXI_ROLE_BRESP,
  output logic                S_AXI_ROLE_BVALID,
  input  logic                S_AXI_ROLE_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ROLE_ARADDR,
  input  logic [7:0]          S_AXI_ROLE_ARLEN,
  input  logic [2:0]          S_AXI_ROLE_ARSIZE,
  input  logic [1:0]          S_AXI_ROLE_ARBURST,
  input  logic                S_AXI_ROLE_ARVALID,
  output logic                S_AXI_ROLE_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_ROLE_RDATA,
  output logic [1:0]          S_AXI_ROLE_RRESP,
  output logic                S_AXI_ROLE_RLAST,
  output logic                S_AXI_ROLE_RVALID,
  input  logic                S_AXI_ROLE_RREADY,
  // static side (we are the master)
  output logic [ADDR_W-1:0]   M_AXI_STATIC_AWADDR,
  output logic [7:0]          M_AXI_STATIC_AWLEN,
  output logic [2:0]          M_AXI_STATIC_AWSIZE,
  output logic [1:0]          M_AXI_STATIC_AWBURST,
  output logic                M_AXI_STATIC_AWVALID,
  input  logic                M_AXI_STATIC_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_STATIC_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_STATIC_WSTRB,
  output logic                M_AXI_STATIC_WLAST,
  output logic                M_AXI_STATIC_WVALID,
  input  logic                M_AXI_STATIC_WREADY,
  input  logic [1:0]          M_AXI_STATIC_BRESP,
  input  logic                M_AXI_STATIC_BVALID,
  output logic                M_AXI_STATIC_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_STATIC_ARADDR,
  output logic [7:0]          M_AXI_STATIC_ARLEN,
  output logic [2:0]          M_AXI_STATIC_ARSIZE,
  output logic [1:0]          M_AXI_STATIC_ARBURST,
  output logic                M_AXI_STATIC_ARVALID,
  input  logic                M_AXI_STATIC_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_STATIC_RDATA,
  input  logic [1:0]          M_AXI_STATIC_RRESP,
  input  logic                M_AXI_STATIC_RLAST,
  input  logic                M_AXI_STATIC_RVALID,
  output logic                M_AXI_STATIC_RREADY
);

  state_t state;
  logic   ack_q;

  logic [NUM_CNT-1:0]            inc, dec, full, empty;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic                          clr;

  logic run, live, iso, aw_ok, ar_ok, w_ok, drained;

  assign run  = (state == RUN);
  assign iso  = (state == DECOUPLED);
  assign live = !iso;

  // AW also waits on w_pend so the wlast bookkeeping can never saturate.
  assign aw_ok   = run && !full[CNT_WR] && !full[CNT_WP];
  assign ar_ok   = run && !full[CNT_RD];
  // W is held until its AW is accepted; a slave may legally wait for AW.
  assign w_ok    = live && !empty[CNT_WP];
  assign drained = &empty;

  // payload pass-through
  assign M_AXI_STATIC_AWADDR  = S_AXI_ROLE_AWADDR;
  assign M_AXI_STATIC_AWLEN   = S_AXI_ROLE_AWLEN;
  assign M_AXI_STATIC_AWSIZE  = S_AXI_ROLE_AWSIZE;
  assign M_AXI_STATIC_AWBURST = S_AXI_ROLE_AWBURST;
  assign M_AXI_STATIC_WDATA   = S_AXI_ROLE_WDATA;
  assign M_AXI_STATIC_WSTRB   = S_AXI_ROLE_WSTRB;
  assign M_AXI_STATIC_WLAST   = S_AXI_ROLE_WLAST;
  assign S_AXI_ROLE_BRESP     = M_AXI_STATIC_BRESP;
  assign M_AXI_STATIC_ARADDR  = S_AXI_ROLE_ARADDR;
  assign M_AXI_STATIC_ARLEN   = S_AXI_ROLE_ARLEN;
  assign M_AXI_STATIC_ARSIZE  = S_AXI_ROLE_ARSIZE;
  assign M_AXI_STATIC_ARBURST = S_AXI_ROLE_ARBURST;
  assign S_AXI_ROLE_RDATA     = M_AXI_STATIC_RDATA;
  assign S_AXI_ROLE_RRESP     = M_AXI_STATIC_RRESP;
  assign S_AXI_ROLE_RLAST     = M_AXI_STATIC_RLAST;

  // handshake gating; isolated static side sinks any stray B/R
  assign M_AXI_STATIC_AWVALID = S_AXI_ROLE_AWVALID   && aw_ok;
  assign S_AXI_ROLE_AWREADY   = M_AXI_STATIC_AWREADY && aw_ok;
  assign M_AXI_STATIC_WVALID  = S_AXI_ROLE_WVALID    && w_ok;
  assign S_AXI_ROLE_WREADY    = M_AXI_STATIC_WREADY  && w_ok;
  assign S_AXI_ROLE_BVALID    = M_AXI_STATIC_BVALID  && live;
  assign M_AXI_STATIC_BREADY  = iso || S_AXI_ROLE_BREADY;
  assign M_AXI_STATIC_ARVALID = S_AXI_ROLE_ARVALID   && ar_ok;
  assign S_AXI_ROLE_ARREADY   = M_AXI_STATIC_ARREADY && ar_ok;
  assign S_AXI_ROLE_RVALID    = M_AXI_STATIC_RVALID  && live;
  assign M_AXI_STATIC_RREADY  = iso || S_AXI_ROLE_RREADY;

  // handshakes seen by the role (stray responses while isolated don't count)
  assign inc[CNT_WR] = S_AXI_ROLE_AWVALID && S_AXI_ROLE_AWREADY;
  assign dec[CNT_WR] = S_AXI_ROLE_BVALID  && S_AXI_ROLE_BREADY;
  assign inc[CNT_RD] = S_AXI_ROLE_ARVALID && S_AXI_ROLE_ARREADY;
  assign dec[CNT_RD] = S_AXI_ROLE_RVALID  && S_AXI_ROLE_RREADY && M_AXI_STATIC_RLAST;
  assign inc[CNT_WP] = inc[CNT_WR];
  assign dec[CNT_WP] = S_AXI_ROLE_WVALID  && S_AXI_ROLE_WREADY && S_AXI_ROLE_WLAST;

  // counters restart from zero together with the DECOUPLED->RUN transition
  assign clr = iso && !DECOUPLE_REQ;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    outstanding_cnt #(.CNT_W(CNT_W), .MAX(MAX_OUTSTANDING)) u_cnt (
      .gclk  (CLK_IN_250),
      .grst_n(AXI_RESET_N),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .clr   (clr),
      .cnt   (cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign OUTSTANDING_WR = cnt[CNT_WR];
  assign OUTSTANDING_RD = cnt[CNT_RD];
  assign DECOUPLE_ACK   = ack_q;

`ifdef ROLE_DECOUPLE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;
  logic             tmo_q;
  assign DRAIN_TIMEOUT = tmo_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign DRAIN_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK_IN_250) begin
    if (!AXI_RESET_N) begin
      state <= RUN;
      ack_q <= 1'b0;
`ifdef ROLE_DECOUPLE_TIMEOUT_EN
      timer <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (DECOUPLE_REQ) state <= BLOCK;
`ifdef ROLE_DECOUPLE_TIMEOUT_EN
          timer <= '0;
`endif
        end
        BLOCK: begin
          // a dropped request aborts the drain and keeps the counts
          if (!DECOUPLE_REQ) begin
            state <= RUN;
          end else if (drained) begin
            state <= DECOUPLED;
            ack_q <= 1'b1;
          end
`ifdef ROLE_DECOUPLE_TIMEOUT_EN
          else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state <= DECOUPLED;
            ack_q <= 1'b1;
            tmo_q <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
`endif
        end
        DECOUPLED: begin
          if (!DECOUPLE_REQ) begin
            state <= RUN;
            ack_q <= 1'b0;
`ifdef ROLE_DECOUPLE_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
          end
        end
        default: begin
          state <= RUN;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_role_axi_decoupler.sv
module tb_role_axi_decoupler;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = 3;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic ack, tmo;
  logic [CW-1:0] out_wr, out_rd;

  logic [AW-1:0] r_awaddr = '0, s_awaddr, r_araddr = '0, s_araddr;
  logic [7:0] r_awlen = '0, s_awlen, r_arlen = '0, s_arlen;
  logic [2:0] r_awsize = 3'd2, s_awsize, r_arsize = 3'd2, s_arsize;
  logic [1:0] r_awburst = 2'd1, s_awburst, r_arburst = 2'd1, s_arburst;
  logic r_awvalid = 0, r_awready, s_awvalid, s_awready = 0;
  logic [DW-1:0] r_wdata = '0, s_wdata, r_rdata, s_rdata = '0;
  logic [DW/8-1:0] r_wstrb = '1, s_wstrb;
  logic r_wlast = 0, s_wlast, r_wvalid = 0, r_wready, s_wvalid, s_wready = 0;
  logic [1:0] r_bresp, s_bresp = '0, r_rresp, s_rresp = '0;
  logic r_bvalid, r_bready = 0, s_bvalid = 0, s_bready;
  logic r_arvalid = 0, r_arready, s_arvalid, s_arready = 0;
  logic r_rlast, s_rlast = 0, r_rvalid, r_rready = 0, s_rvalid = 0, s_rready;

  always #5 clk = ~clk;

  role_axi_decoupler #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(16)) dut (
    .CLK_IN_250(clk), .AXI_RESET_N(rst_n), .DECOUPLE_REQ(req), .DECOUPLE_ACK(ack),
    .DRAIN_TIMEOUT(tmo), .OUTSTANDING_WR(out_wr), .OUTSTANDING_RD(out_rd),
    .S_AXI_ROLE_AWADDR(r_awaddr), .S_AXI_ROLE_AWLEN(r_awlen), .S_AXI_ROLE_AWSIZE(r_awsize),
    .S_AXI_ROLE_AWBURST(r_awburst), .S_AXI_ROLE_AWVALID(r_awvalid), .S_AXI_ROLE_AWREADY(r_awready),
    .S_AXI_ROLE_WDATA(r_wdata), .S_AXI_ROLE_WSTRB(r_wstrb), .S_AXI_ROLE_WLAST(r_wlast),
    .S_AXI_ROLE_WVALID(r_wvalid), .S_AXI_ROLE_WREADY(r_wready),
    .S_AXI_ROLE_BRESP(r_bresp), .S_AXI_ROLE_BVALID(r_bvalid), .S_AXI_ROLE_BREADY(r_bready),
    .S_AXI_ROLE_ARADDR(r_araddr), .S_AXI_ROLE_ARLEN(r_arlen), .S_AXI_ROLE_ARSIZE(r_arsize),
    .S_AXI_ROLE_ARBURST(r_arburst), .S_AXI_ROLE_ARVALID(r_arvalid), .S_AXI_ROLE_ARREADY(r_arready),
    .S_AXI_ROLE_RDATA(r_rdata), .S_AXI_ROLE_RRESP(r_rresp), .S_AXI_ROLE_RLAST(r_rlast),
    .S_AXI_ROLE_RVALID(r_rvalid), .S_AXI_ROLE_RREADY(r_rready),
    .M_AXI_STATIC_AWADDR(s_awaddr), .M_AXI_STATIC_AWLEN(s_awlen), .M_AXI_STATIC_AWSIZE(s_awsize),
    .M_AXI_STATIC_AWBURST(s_awburst), .M_AXI_STATIC_AWVALID(s_awvalid), .M_AXI_STATIC_AWREADY(s_awready),
    .M_AXI_STATIC_WDATA(s_wdata), .M_AXI_STATIC_WSTRB(s_wstrb), .M_AXI_STATIC_WLAST(s_wlast),
    .M_AXI_STATIC_WVALID(s_wvalid), .M_AXI_STATIC_WREADY(s_wready),
    .M_AXI_STATIC_BRESP(s_bresp), .M_AXI_STATIC_BVALID(s_bvalid), .M_AXI_STATIC_BREADY(s_bready),
    .M_AXI_STATIC_ARADDR(s_araddr), .M_AXI_STATIC_ARLEN(s_arlen), .M_AXI_STATIC_ARSIZE(s_arsize),
    .M_AXI_STATIC_ARBURST(s_arburst), .M_AXI_STATIC_ARVALID(s_arvalid), .M_AXI_STATIC_ARREADY(s_arready),
    .M_AXI_STATIC_RDATA(s_rdata), .M_AXI_STATIC_RRESP(s_rresp), .M_AXI_STATIC_RLAST(s_rlast),
    .M_AXI_STATIC_RVALID(s_rvalid), .M_AXI_STATIC_RREADY(s_rready)
  );

  // inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", tmo); end
    checks++; if (out_wr !== 3'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", out_wr); end
    checks++; if (out_rd !== 3'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", out_rd); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_writes();
    s_awready = 1; s_wready = 1; r_bready = 1;
    for (int i = 0; i < 4; i++) begin
      r_awvalid = 1; r_awaddr = 32'h1000 + 32'(i * 64); r_awlen = 8'd3;
      @(negedge clk);
      checks++; if (s_awvalid !== 1'b1 || r_awready !== 1'b1) begin errors++;
        $display("FAIL wr_aw_hs%0d: got valid %b ready %b want 1 1", i, s_awvalid, r_awready); end
      checks++; if (s_awaddr !== 32'h1000 + 32'(i * 64) || s_awlen !== 8'd3) begin errors++;
        $display("FAIL wr_aw_payload%0d: got %0h/%0d want %0h/3", i, s_awaddr, s_awlen, 32'h1000 + 32'(i * 64)); end
      step();
      checks++; if (out_wr !== 3'(i + 1)) begin errors++; $display("FAIL wr_cnt_up%0d: got %0d want %0d", i, out_wr, i + 1); end
    end
    r_awaddr = 32'h2000;
    @(negedge clk);
    checks++; if (r_awready !== 1'b0 || s_awvalid !== 1'b0) begin errors++;
      $display("FAIL wr_aw_full: got ready %b valid %b want 0 0", r_awready, s_awvalid); end
    step();
    r_awvalid = 0;
    checks++; if (out_wr !== 3'd4) begin errors++; $display("FAIL wr_cnt_sat: got %0d want 4", out_wr); end
    for (int i = 0; i < 16; i++) begin
      r_wvalid = 1; r_wdata = 32'hA500_0000 | 32'(i); r_wlast = (i % 4 == 3);
      @(negedge clk);
      checks++; if (s_wvalid !== 1'b1 || r_wready !== 1'b1 || s_wdata !== (32'hA500_0000 | 32'(i))
                    || s_wlast !== (i % 4 == 3)) begin errors++;
        $display("FAIL wr_w_beat%0d: got v%b r%b d%0h l%b", i, s_wvalid, r_wready, s_wdata, s_wlast); end
      step();
    end
    r_wvalid = 0; r_wlast = 0;
    for (int i = 0; i < 4; i++) begin
      s_bvalid = 1; s_bresp = 2'(i);
      @(negedge clk);
      checks++; if (r_bvalid !== 1'b1 || s_bready !== 1'b1 || r_bresp !== 2'(i)) begin errors++;
        $display("FAIL wr_b%0d: got v%b r%b resp%0d want 1 1 %0d", i, r_bvalid, s_bready, r_bresp, i); end
      step();
      checks++; if (out_wr !== 3'(3 - i)) begin errors++; $display("FAIL wr_cnt_dn%0d: got %0d want %0d", i, out_wr, 3 - i); end
    end
    s_bvalid = 0; s_bresp = 0;
  endtask

  task automatic test_read_limit();
    s_arready = 1; r_rready = 0;
    for (int i = 0; i < 4; i++) begin
      r_arvalid = 1; r_araddr = 32'h3000 + 32'(i * 256); r_arlen = 8'd0;
      @(negedge clk);
      checks++; if (r_arready !== 1'b1 || s_araddr !== 32'h3000 + 32'(i * 256)) begin errors++;
        $display("FAIL rd_ar%0d: got ready %b addr %0h", i, r_arready, s_araddr); end
      step();
      checks++; if (out_rd !== 3'(i + 1)) begin errors++; $display("FAIL rd_cnt_up%0d: got %0d want %0d", i, out_rd, i + 1); end
    end
    r_araddr = 32'h3400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (r_arready !== 1'b0 || s_arvalid !== 1'b0) begin errors++;
        $display("FAIL rd_ar_full%0d: got ready %b valid %b want 0 0", i, r_arready, s_arvalid); end
      step();
      checks++; if (out_rd !== 3'd4) begin errors++; $display("FAIL rd_cnt_hold%0d: got %0d want 4", i, out_rd); end
    end
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hDEAD_0001; r_rready = 1;
    @(negedge clk);
    checks++; if (r_rvalid !== 1'b1 || r_rdata !== 32'hDEAD_0001 || r_arready !== 1'b0) begin errors++;
      $display("FAIL rd_first_rlast: got v%b d%0h arready%b", r_rvalid, r_rdata, r_arready); end
    step();
    checks++; if (out_rd !== 3'd3) begin errors++; $display("FAIL rd_cnt_after_rlast: got %0d want 3", out_rd); end
    s_rvalid = 0; r_rready = 0;
    @(negedge clk);
    checks++; if (r_arready !== 1'b1 || s_araddr !== 32'h3400) begin errors++;
      $display("FAIL rd_ar_reopen: got ready %b addr %0h", r_arready, s_araddr); end
    step();
    r_arvalid = 0;
    checks++; if (out_rd !== 3'd4) begin errors++; $display("FAIL rd_cnt_refill: got %0d want 4", out_rd); end
    s_rvalid = 1; s_rlast = 0; r_rready = 1;
    step();
    checks++; if (out_rd !== 3'd4) begin errors++; $display("FAIL rd_nonlast: got %0d want 4", out_rd); end
    s_rlast = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_rd !== 3'(3 - i)) begin errors++; $display("FAIL rd_cnt_dn%0d: got %0d want %0d", i, out_rd, 3 - i); end
    end
    s_rvalid = 0; s_rlast = 0; r_rready = 0;
  endtask

  task automatic test_w_before_aw();
    r_wvalid = 1; r_wdata = 32'h11; r_wlast = 0;
    @(negedge clk);
    checks++; if (r_wready !== 1'b0 || s_wvalid !== 1'b0) begin errors++;
      $display("FAIL wfirst_stall: got ready %b valid %b want 0 0", r_wready, s_wvalid); end
    step();
    r_awvalid = 1; r_awaddr = 32'h4000; r_awlen = 8'd1;
    @(negedge clk);
    checks++; if (r_awready !== 1'b1 || r_wready !== 1'b0) begin errors++;
      $display("FAIL wfirst_aw_cycle: got awready %b wready %b want 1 0", r_awready, r_wready); end
    step();
    r_awvalid = 0;
    @(negedge clk);
    checks++; if (r_wready !== 1'b1 || s_wvalid !== 1'b1 || s_wdata !== 32'h11) begin errors++;
      $display("FAIL wfirst_beat0: got r%b v%b d%0h", r_wready, s_wvalid, s_wdata); end
    step();
    r_wdata = 32'h22; r_wlast = 1;
    @(negedge clk);
    checks++; if (r_wready !== 1'b1 || s_wlast !== 1'b1) begin errors++;
      $display("FAIL wfirst_last: got r%b l%b want 1 1", r_wready, s_wlast); end
    step();
    r_wdata = 32'h33; r_wlast = 0;
    @(negedge clk);
    checks++; if (r_wready !== 1'b0) begin errors++; $display("FAIL wfirst_pend_zero: got %b want 0", r_wready); end
    step();
    r_wvalid = 0; s_bvalid = 1; r_bready = 1;
    step();
    s_bvalid = 0;
    checks++; if (out_wr !== 3'd0) begin errors++; $display("FAIL wfirst_wr_done: got %0d want 0", out_wr); end
  endtask

  task automatic test_decouple_drain();
    r_awvalid = 1; r_awaddr = 32'h5000; r_awlen = 8'd3;
    step();
    r_awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      r_wvalid = 1; r_wdata = 32'(i); r_wlast = 0;
      step();
    end
    r_wvalid = 0; req = 1;
    step();
    r_arvalid = 1; r_araddr = 32'h5100; r_awvalid = 1; r_awaddr = 32'h5200;
    @(negedge clk);
    checks++; if (r_arready !== 1'b0 || s_arvalid !== 1'b0 || r_awready !== 1'b0 || s_awvalid !== 1'b0) begin errors++;
      $display("FAIL dc_block_addr: got ar %b/%b aw %b/%b want all 0", r_arready, s_arvalid, r_awready, s_awvalid); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL dc_ack_early: got %b want 0", ack); end
    for (int i = 2; i < 4; i++) begin
      r_wvalid = 1; r_wdata = 32'(i); r_wlast = (i == 3);
      @(negedge clk);
      checks++; if (r_wready !== 1'b1 || s_wvalid !== 1'b1) begin errors++;
        $display("FAIL dc_w_beat%0d: got r%b v%b want 1 1", i, r_wready, s_wvalid); end
      step();
    end
    r_wvalid = 0; r_wlast = 0; s_bvalid = 1;
    @(negedge clk);
    checks++; if (r_bvalid !== 1'b1) begin errors++; $display("FAIL dc_b_pass: got %b want 1", r_bvalid); end
    step();
    s_bvalid = 0;
    checks++; if (out_wr !== 3'd0 || out_rd !== 3'd0 || ack !== 1'b0) begin errors++;
      $display("FAIL dc_zero_cycle: got wr%0d rd%0d ack%b want 0 0 0", out_wr, out_rd, ack); end
    step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL dc_ack: got %b want 1", ack); end
  endtask

  task automatic test_isolated();
    r_wvalid = 1; s_rvalid = 1; s_rlast = 1; s_bvalid = 1; r_rready = 0; r_bready = 0;
    @(negedge clk);
    checks++; if (s_rready !== 1'b1 || r_rvalid !== 1'b0 || s_bready !== 1'b1 || r_bvalid !== 1'b0) begin errors++;
      $display("FAIL iso_sink: got srready%b rrvalid%b sbready%b rbvalid%b", s_rready, r_rvalid, s_bready, r_bvalid); end
    checks++; if (r_arready !== 1'b0 || s_arvalid !== 1'b0 || r_awready !== 1'b0 || s_awvalid !== 1'b0
                  || r_wready !== 1'b0 || s_wvalid !== 1'b0) begin errors++;
      $display("FAIL iso_req_gate: got ar%b%b aw%b%b w%b%b want all 0", r_arready, s_arvalid,
               r_awready, s_awvalid, r_wready, s_wvalid); end
    step();
    r_wvalid = 0; s_rvalid = 0; s_rlast = 0; s_bvalid = 0; r_arvalid = 0; r_awvalid = 0; req = 0;
    step();
    checks++; if (ack !== 1'b0 || out_wr !== 3'd0 || out_rd !== 3'd0) begin errors++;
      $display("FAIL iso_recouple: got ack%b wr%0d rd%0d want 0 0 0", ack, out_wr, out_rd); end
    r_arvalid = 1; r_araddr = 32'h6000;
    @(negedge clk);
    checks++; if (r_arready !== 1'b1) begin errors++; $display("FAIL iso_run_ar: got %b want 1", r_arready); end
    step();
    r_arvalid = 0; s_rvalid = 1; s_rlast = 1; r_rready = 1;
    step();
    s_rvalid = 0; s_rlast = 0; r_rready = 0;
    checks++; if (out_rd !== 3'd0) begin errors++; $display("FAIL iso_run_rd: got %0d want 0", out_rd); end
  endtask

  task automatic test_abort();
    r_awvalid = 1; r_awaddr = 32'h7000; r_awlen = 8'd0;
    step();
    r_awvalid = 0; req = 1;
    step();
    r_arvalid = 1;
    @(negedge clk);
    checks++; if (r_arready !== 1'b0) begin errors++; $display("FAIL abort_block_ar: got %b want 0", r_arready); end
    step();
    r_arvalid = 0;
    step();
    req = 0;
    step();
    checks++; if (out_wr !== 3'd1 || ack !== 1'b0) begin errors++;
      $display("FAIL abort_kept: got wr%0d ack%b want 1 0", out_wr, ack); end
    r_wvalid = 1; r_wlast = 1;
    step();
    r_wvalid = 0; r_wlast = 0; s_bvalid = 1; r_bready = 1;
    step();
    s_bvalid = 0;
    checks++; if (out_wr !== 3'd0) begin errors++; $display("FAIL abort_done: got %0d want 0", out_wr); end
  endtask

`ifdef ROLE_DECOUPLE_TIMEOUT_EN
  task automatic test_timeout();
    r_awvalid = 1; r_awaddr = 32'h8000; r_awlen = 8'd3;
    step();
    r_awvalid = 0; req = 1;
    step();
    repeat (15) step();
    checks++; if (ack !== 1'b0 || tmo !== 1'b0) begin errors++;
      $display("FAIL tmo_early: got ack%b tmo%b want 0 0", ack, tmo); end
    step();
    checks++; if (ack !== 1'b1 || tmo !== 1'b1) begin errors++;
      $display("FAIL tmo_fire: got ack%b tmo%b want 1 1", ack, tmo); end
    req = 0;
    step();
    checks++; if (ack !== 1'b0 || tmo !== 1'b0 || out_wr !== 3'd0) begin errors++;
      $display("FAIL tmo_clear: got ack%b tmo%b wr%0d want 0 0 0", ack, tmo, out_wr); end
  endtask
`else
  task automatic test_block_waits();
    r_awvalid = 1; r_awaddr = 32'h8000; r_awlen = 8'd0;
    step();
    r_awvalid = 0; req = 1;
    repeat (30) step();
    checks++; if (ack !== 1'b0 || tmo !== 1'b0) begin errors++;
      $display("FAIL block_wait: got ack%b tmo%b want 0 0", ack, tmo); end
    r_wvalid = 1; r_wlast = 1;
    step();
    r_wvalid = 0; r_wlast = 0; s_bvalid = 1; r_bready = 1;
    step();
    s_bvalid = 0;
    step();
    checks++; if (ack !== 1'b1 || tmo !== 1'b0) begin errors++;
      $display("FAIL block_drained: got ack%b tmo%b want 1 0", ack, tmo); end
    req = 0;
    step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL block_recouple: got %b want 0", ack); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    r_awvalid = 1; r_awaddr = 32'h9000; r_awlen = 8'd3;
    step();
    r_awvalid = 0; r_wvalid = 1; r_wlast = 0;
    checks++; if (out_wr !== 3'd1) begin errors++; $display("FAIL rstmid_pre: got %0d want 1", out_wr); end
    rst_n = 0;
    step();
    checks++; if (out_wr !== 3'd0 || ack !== 1'b0) begin errors++;
      $display("FAIL rstmid_clear: got wr%0d ack%b want 0 0", out_wr, ack); end
    rst_n = 1;
    step();
    @(negedge clk);
    checks++; if (r_wready !== 1'b0) begin errors++; $display("FAIL rstmid_wgate: got %b want 0", r_wready); end
    r_wvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_writes();
    test_read_limit();
    test_w_before_aw();
    test_decouple_drain();
    test_isolated();
    test_abort();
`ifdef ROLE_DECOUPLE_TIMEOUT_EN
    test_timeout();
`else
    test_block_waits();
`endif
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
